gf2273_inverse: RTL and testbench



---
 rtl/gf2273_pkg.sv | 19 +
 rtl/gf2273_inverse_if.sv | 23 ++
 rtl/gf2273_modmul.sv | 33 +++
 rtl/gf2273_inverse.sv | 97 +++++++++
 tb/tb_gf2273_inverse.sv | 127 ++++++++++++
 5 files changed

// File: rtl/gf2273_pkg.sv
// Shared constants and state encoding for the GF(2273) Fermat inverter.
// Q is prime, so a^(Q-2) is the multiplicative inverse of any nonzero residue.
package gf2273_pkg;

  localparam int W  = 12;
  localparam int PW = 23;

  localparam logic [W-1:0] Q   = 12'd2273;
  localparam logic [12:0]  MU  = 13'd7381;
  localparam logic [W-1:0] EXP = 12'b1000_1101_1111;

  typedef enum logic [1:0] {
    IDLE,
    SQR,
    MUL,
    DONE
  } state_t;

endpackage

// File: rtl/gf2273_inverse_if.sv
// Operand/result handshake bundle for the GF(2273) inverter.
// master drives operands and consumes results; slave is the inverter.
interface gf2273_inverse_if;

  logic                     in_valid;
  logic                     in_ready;
  logic [gf2273_pkg::W-1:0] din_a;
  logic                     out_valid;
  logic                     out_ready;
  logic [gf2273_pkg::W-1:0] dout_inv;
  logic                     zero_err;

  modport master (
    output in_valid, din_a, out_ready,
    input  in_ready, out_valid, dout_inv, zero_err
  );

  modport slave (
    input  in_valid, din_a, out_ready,
    output in_ready, out_valid, dout_inv, zero_err
  );

endinterface

// File: rtl/gf2273_modmul.sv
// Combinational 12x12 multiply followed by Barrett reduction mod 2273.
// Both operands must already be below Q, so the product is below 2^23.
module gf2273_modmul
  import gf2273_pkg::*;
(
  input  logic [W-1:0] x_i,
  input  logic [W-1:0] y_i,
  output logic [W-1:0] r_o
);

  logic [PW-1:0] prod;
  logic [10:0]   prodHi;
  logic [23:0]   qEst;
  logic [W-1:0]  quot;
  logic [PW-1:0] quotQ;
  logic [PW-1:0] rem0;
  logic [PW-1:0] rem1;
  logic [PW-1:0] rem2;

  // The truncated quotient can fall up to two short, so the remainder gets two correction steps.
  always_comb begin
    prod   = {11'b0, x_i} * {11'b0, y_i};
    prodHi = 11'(prod >> W);
    qEst   = {13'b0, prodHi} * {11'b0, MU};
    quot   = W'(qEst >> 12);
    quotQ  = {11'b0, quot} * {11'b0, Q};
    rem0   = prod - quotQ;
    rem1   = (rem0 >= {11'b0, Q}) ? rem0 - {11'b0, Q} : rem0;
    rem2   = (rem1 >= {11'b0, Q}) ? rem1 - {11'b0, Q} : rem1;
    r_o    = W'(rem2);
  end

endmodule

// File: rtl/gf2273_inverse.sv
// Sequential modular inverter: left-to-right square-and-multiply of a^(Q-2) mod Q,
// one modular multiply per cycle, fixed 20-cycle latency, one operation in flight.
module gf2273_inverse
  import gf2273_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  gf2273_inverse_if.slave bus
);

  state_t       state_q;
  logic [3:0]   bitIdx_q;
  logic [W-1:0] acc_q;
  logic [W-1:0] aRed_q;
  logic         inReady_q;
  logic         outValid_q;
  logic [W-1:0] doutInv_q;
  logic         zeroErr_q;

  logic [W-1:0] aRedIn;
  logic [W-1:0] mulB;
  logic [W-1:0] mulRes;

  // Operands reach at most 4095 < 2Q, so one subtraction fully reduces them.
  assign aRedIn = (bus.din_a >= Q) ? bus.din_a - Q : bus.din_a;
  assign mulB   = (state_q == MUL) ? aRed_q : acc_q;

  gf2273_modmul uModmul (
    .x_i (acc_q),
    .y_i (mulB),
    .r_o (mulRes)
  );

  assign bus.in_ready  = inReady_q;
  assign bus.out_valid = outValid_q;
  assign bus.dout_inv  = doutInv_q;
  assign bus.zero_err  = zeroErr_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      bitIdx_q   <= 4'd11;
      acc_q      <= W'(1);
      aRed_q     <= '0;
      inReady_q  <= 1'b1;
      outValid_q <= 1'b0;
      doutInv_q  <= '0;
      zeroErr_q  <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (bus.in_valid && inReady_q) begin
            aRed_q    <= aRedIn;
            acc_q     <= W'(1);
            bitIdx_q  <= 4'd11;
            inReady_q <= 1'b0;
            state_q   <= SQR;
          end
        end
        SQR: begin
          acc_q <= mulRes;
          if (EXP[bitIdx_q]) begin
            state_q <= MUL;
          end else if (bitIdx_q == 4'd0) begin
            state_q    <= DONE;
            outValid_q <= 1'b1;
            doutInv_q  <= mulRes;
            zeroErr_q  <= (aRed_q == '0);
          end else begin
            bitIdx_q <= bitIdx_q - 4'd1;
          end
        end
        MUL: begin
          acc_q <= mulRes;
          if (bitIdx_q == 4'd0) begin
            state_q    <= DONE;
            outValid_q <= 1'b1;
            doutInv_q  <= mulRes;
            zeroErr_q  <= (aRed_q == '0);
          end else begin
            bitIdx_q <= bitIdx_q - 4'd1;
            state_q  <= SQR;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            outValid_q <= 1'b0;
            inReady_q  <= 1'b1;
            state_q    <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_gf2273_inverse.sv
// Directed bench for gf2273_inverse: hand-computed inverses, latency, backpressure,
// busy-time input rejection and mid-operation reset.
module tb_gf2273_inverse;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checkCount = 0;
  int   failCount  = 0;

  gf2273_inverse_if bus ();

  gf2273_inverse dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checkCount++;
    if (got !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // Accepts one operand, checks latency and busy in_ready, holds off the consumer, then drains.
  task automatic applyStimulus(input string tag, input logic [11:0] a, input logic [11:0] expInv,
                               input logic expZero, input int holdCycles);
    int   cycles;
    logic readyBad;
    checkOutput({tag, "_idle_ready"}, 32'(bus.in_ready), 32'd1);
    bus.din_a    = a;
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.din_a    = '0;
    cycles   = 0;
    readyBad = 1'b0;
    while (!bus.out_valid && cycles < 100) begin
      if (bus.in_ready) readyBad = 1'b1;
      @(posedge clk); #1;
      cycles++;
    end
    checkOutput({tag, "_latency"}, 32'(cycles), 32'd20);
    checkOutput({tag, "_busy_ready"}, 32'(readyBad), 32'd0);
    for (int i = 0; i < holdCycles; i++) begin
      @(posedge clk); #1;
      checkOutput({tag, "_hold_valid"}, 32'(bus.out_valid), 32'd1);
      checkOutput({tag, "_hold_inv"}, 32'(bus.dout_inv), 32'(expInv));
      checkOutput({tag, "_hold_ready"}, 32'(bus.in_ready), 32'd0);
    end
    checkOutput({tag, "_inv"}, 32'(bus.dout_inv), 32'(expInv));
    checkOutput({tag, "_zero_err"}, 32'(bus.zero_err), 32'(expZero));
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    checkOutput({tag, "_drained_valid"}, 32'(bus.out_valid), 32'd0);
    checkOutput({tag, "_drained_ready"}, 32'(bus.in_ready), 32'd1);
  endtask

  initial begin
    logic seen;
    bus.in_valid  = 1'b0;
    bus.din_a     = '0;
    bus.out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    checkOutput("reset_in_ready", 32'(bus.in_ready), 32'd1);
    checkOutput("reset_out_valid", 32'(bus.out_valid), 32'd0);
    checkOutput("reset_dout_inv", 32'(bus.dout_inv), 32'd0);
    checkOutput("reset_zero_err", 32'(bus.zero_err), 32'd0);

    applyStimulus("op1", 12'd1, 12'd1, 1'b0, 0);
    applyStimulus("op2", 12'd2, 12'd1137, 1'b0, 0);
    applyStimulus("op3", 12'd3, 12'd758, 1'b0, 0);
    applyStimulus("op2272", 12'd2272, 12'd2272, 1'b0, 0);
    applyStimulus("op5", 12'd5, 12'd1364, 1'b0, 0);
    applyStimulus("op2275", 12'd2275, 12'd1137, 1'b0, 0);
    applyStimulus("op2273", 12'd2273, 12'd0, 1'b1, 0);
    applyStimulus("op0", 12'd0, 12'd0, 1'b1, 0);
    applyStimulus("backpressure", 12'd2, 12'd1137, 1'b0, 10);

    // A second operand offered while busy must not disturb the running inverse of 4.
    fork
      applyStimulus("busy_in", 12'd4, 12'd1705, 1'b0, 0);
      begin
        repeat (3) @(posedge clk);
        for (int i = 0; i < 6; i++) begin
          #1;
          bus.din_a    = 12'd5;
          bus.in_valid = (i % 2 == 0);
          @(posedge clk);
        end
        #1;
        bus.in_valid = 1'b0;
        bus.din_a    = '0;
      end
    join

    bus.din_a    = 12'd3;
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.din_a    = '0;
    repeat (6) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checkOutput("rst_mid_out_valid", 32'(bus.out_valid), 32'd0);
    checkOutput("rst_mid_in_ready", 32'(bus.in_ready), 32'd1);
    seen = 1'b0;
    repeat (25) begin
      @(posedge clk); #1;
      if (bus.out_valid) seen = 1'b1;
    end
    checkOutput("rst_mid_no_result", 32'(seen), 32'd0);
    applyStimulus("after_rst", 12'd2, 12'd1137, 1'b0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", checkCount, failCount);
    $finish;
  end

endmodule
